lsu_mem_port: RTL
=================

# lsu_mem_port

Memory-port stage between the multicycle datapath and the single unified instruction/data memory. It accepts one fetch, load or store request at a time from the control FSM's memory states and runs a valid/ready transaction to memory. It steers byte lanes for stores and aligns and extends load data, faulting misaligned or illegal accesses. It holds the instruction register whose fields (opcode, funct3) feed the control unit, and the load-data register consumed by the write-back state.

## Interface
Parameters:
- RESET_INSTR, 32'h0000_0013: instruction-register reset value (NOP, `addi x0,x0,0`).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- resetn  in  1  asynchronous active-low reset.
- req_fetch  in  1  request an instruction fetch at `addr`; result goes to `instr`.
- req_read  in  1  request a load at `addr` with width/sign from `funct3`.
- req_write  in  1  request a store of `wdata` at `addr` with width from `funct3`.
- funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- addr  in  32  byte address.
- wdata  in  32  store data, right-aligned (rs2).
- busy  out  1  high while a transaction is outstanding; the control FSM stalls on it.
- done  out  1  one-cycle pulse: request completed or faulted.
- fault  out  1  one-cycle pulse, coincident with `done`, for a misaligned or illegal request.
- instr  out  32  instruction register.
- op  out  7  `instr[6:0]`.
- instr_funct3  out  3  `instr[14:12]`.
- rdata  out  32  aligned, extended load-data register.
- mem_valid  out  1  memory request valid.
- mem_addr  out  32  word address (`addr` with [1:0] forced to 00).
- mem_wstrb  out  4  byte write strobes; 0000 for reads.
- mem_wdata  out  32  lane-steered store data.
- mem_ready  in  1  memory accepts/completes the current beat.
- mem_rdata  in  32  read data; valid when `mem_valid && mem_ready`.

## Operation
- FSM states:
  - IDLE: requests are sampled.
  - WAIT: `mem_valid` is high.
  - Transitions: IDLE→WAIT on a legal request; WAIT→IDLE on `mem_valid && mem_ready`; IDLE→IDLE on a faulting request.
- Priority when multiple requests are high in IDLE: fetch > write > read. Lower-priority requests are dropped, not queued.
- Requests are ignored while in WAIT.
- Legality:
  - Fetch requires `addr[1:0]==00`.
  - Half accesses (H/HU) require `addr[0]==0`.
  - W requires `addr[1:0]==00`.
  - Loads accept only funct3 000, 001, 010, 100, 101.
  - Stores accept only funct3 000, 001, 010.
  - Any other case is a fault: no memory access, `done` and `fault` pulse, `instr` and `rdata` unchanged.
- Store steering:
  - SB: `wstrb = 1<<addr[1:0]`; `wdata[7:0]` replicated to all four lanes.
  - SH: `wstrb = 0011` when `addr[1]==0`, `1100` when `addr[1]==1`; `wdata[15:0]` replicated to both halves.
  - SW: `wstrb = 1111`.
- Load extraction: the selected byte/half of `mem_rdata` (shifted by `addr[1:0]*8`) is sign-extended (B, H) or zero-extended (BU, HU). W passes the word through.
- Fetch completion loads `mem_rdata` into `instr`. Load completion loads the extracted value into `rdata`. Stores update neither register.
- `addr`, `funct3` and `wdata` are latched at acceptance. The memory-side outputs are driven from the latched values and stay stable in WAIT regardless of input changes.

## Timing
- Reset values:
  - State IDLE.
  - `busy`, `done`, `fault`, `mem_valid` = 0.
  - `mem_wstrb` = 0.
  - `mem_addr`, `mem_wdata` = 0.
  - `rdata` = 0.
  - `instr` = RESET_INSTR.
- Acceptance at edge E0 (IDLE with a request): from E0, `mem_valid` = 1 and `busy` = 1, both registered.
- Completion at the first edge En where `mem_valid && mem_ready`:
  - Data is captured.
  - `mem_valid` and `busy` drop after En.
  - `done` is high for the cycle after En.
- Minimum latency with `mem_ready` tied high: request at cycle 0, `done` in cycle 2.
- Back-to-back operation: a new request may be presented during the `done` cycle (IDLE) and is accepted at that edge.
- Fault: accepted at E0; `done` and `fault` are high the cycle after E0; `busy` never rises.
- Reset mid-transaction: `mem_valid` drops asynchronously, the transaction is abandoned, and no `done` is issued.

## Structure
- Shared package:
  - funct3 size codes.
  - FSM state encoding.
  - NOP constant.
  - Strobe constants.
- Sub-module `lsu_align` (combinational): store lane steering and strobes, plus load extraction and extension. It is instantiated once; the FSM and registers stay in the top module.

## Test plan
- Fetch at 0x0000_0010 with `mem_ready` high and `mem_rdata` = 0x00500093 → `done` in cycle 2, `instr` = 0x00500093, `op` = 0010011, `mem_wstrb` = 0000.
- SB at 0x0000_0103 with `wdata` = 0x1234_56AB → `mem_addr` = 0x100, `wstrb` = 1000, `mem_wdata` = 0xABABABAB.
- LB/LBU at 0x0000_0102 with `mem_rdata` = 0x00F0_0000 → `rdata` = 0xFFFF_FFF0 (LB) and 0x0000_00F0 (LBU); LH at 0x102 with `mem_rdata` = 0x8001_0000 → `rdata` = 0xFFFF_8001.
- LW at 0x0000_0006 → `fault` and `done` pulse in cycle 1, `mem_valid` never high, `rdata` unchanged; SW with funct3 = 011 → same behaviour.
- `mem_ready` held low for 5 cycles during an SH at 0x202 with `wdata` = 0xBEEF while `addr`/`wdata` inputs toggle → `mem_addr`, `mem_wdata` (0xBEEFBEEF) and `wstrb` (1100) stay stable; `done` follows the first `mem_ready`.
- `resetn` pulsed low mid-WAIT → `mem_valid` = 0 immediately, no `done`, `instr` = 0x00000013; a fetch issued after release completes normally.

Source files
------------

// File: rtl/lsu_mem_port_pkg.sv
// lsu_mem_port_pkg: shared encodings, constants and legality check for the LSU memory port.
package lsu_mem_port_pkg;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [3:0] STRB_NONE = 4'b0000;
    localparam logic [3:0] STRB_LO   = 4'b0011;
    localparam logic [3:0] STRB_HI   = 4'b1100;
    localparam logic [3:0] STRB_ALL  = 4'b1111;
    typedef enum logic {S_IDLE, S_WAIT} state_t;
    typedef enum logic [1:0] {K_NONE, K_FETCH, K_READ, K_WRITE} kind_t;
    // Unsigned sizes exist only for loads; stores reject them.
    function automatic logic legal(kind_t k, logic [2:0] f3, logic [1:0] a);
        return k == K_FETCH ? a == 2'b00 :
               f3 == F3_W ? a == 2'b00 :
               (f3 == F3_H || (f3 == F3_HU && k == K_READ)) ? !a[0] :
               (f3 == F3_B || (f3 == F3_BU && k == K_READ));
    endfunction
endpackage

// File: rtl/lsu_mem_port_if.sv
// lsu_mem_port_if: valid/ready memory bus between the LSU port and the unified memory.
interface lsu_mem_port_if;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    modport master (output mem_valid, mem_addr, mem_wstrb, mem_wdata, input mem_ready, mem_rdata);
    modport slave  (input mem_valid, mem_addr, mem_wstrb, mem_wdata, output mem_ready, mem_rdata);
endinterface

// File: rtl/lsu_align.sv
// lsu_align: store lane steering/strobes and load byte/half extraction with extension.
module lsu_align import lsu_mem_port_pkg::*; (
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    input  logic [31:0] raw,
    output logic [3:0]  wstrb,
    output logic [31:0] wlane,
    output logic [31:0] rext
);
    logic [7:0]  b;
    logic [15:0] h;
    always_comb begin
        b = raw[{off, 3'b000} +: 8];
        h = off[1] ? raw[31:16] : raw[15:0];
        wstrb = funct3[1:0] == 2'b00 ? 4'b0001 << off :
                funct3[1:0] == 2'b01 ? (off[1] ? STRB_HI : STRB_LO) : STRB_ALL;
        wlane = funct3[1:0] == 2'b00 ? {4{wdata[7:0]}} :
                funct3[1:0] == 2'b01 ? {2{wdata[15:0]}} : wdata;
        rext = funct3 == F3_B  ? {{24{b[7]}}, b} :
               funct3 == F3_H  ? {{16{h[15]}}, h} :
               funct3 == F3_BU ? {24'h0, b} :
               funct3 == F3_HU ? {16'h0, h} : raw;
    end
endmodule

// File: rtl/lsu_mem_port.sv
// lsu_mem_port: one-at-a-time fetch/load/store port to unified memory,
// holding the instruction register and the load-data register.
module lsu_mem_port import lsu_mem_port_pkg::*; #(
    parameter logic [31:0] RESET_INSTR = NOP
) (
    input  logic           clk,
    input  logic           resetn,
    input  logic           req_fetch,
    input  logic           req_read,
    input  logic           req_write,
    input  logic [2:0]     funct3,
    input  logic [31:0]    addr,
    input  logic [31:0]    wdata,
    output logic           busy,
    output logic           done,
    output logic           fault,
    output logic [31:0]    instr,
    output logic [6:0]     op,
    output logic [2:0]     instr_funct3,
    output logic [31:0]    rdata,
    lsu_mem_port_if.master mem
);
    state_t      state, state_nx;
    kind_t       kind_q, kind_nx;
    logic [2:0]  f3_q;
    logic [31:0] addr_q, wdata_q;
    logic        accept, flt, cmp;
    logic [3:0]  strb;
    logic [31:0] wlane, rext;
    // Fetch outranks write, write outranks read; losers are dropped.
    always_comb begin
        kind_nx = req_fetch ? K_FETCH : req_write ? K_WRITE : req_read ? K_READ : K_NONE;
        accept = state == S_IDLE && kind_nx != K_NONE && legal(kind_nx, funct3, addr[1:0]);
        flt = state == S_IDLE && kind_nx != K_NONE && !legal(kind_nx, funct3, addr[1:0]);
        cmp = state == S_WAIT && mem.mem_ready;
        state_nx = accept ? S_WAIT : cmp ? S_IDLE : state;
    end
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= S_IDLE;
            kind_q  <= K_NONE;
            f3_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            done    <= 1'b0;
            fault   <= 1'b0;
            instr   <= RESET_INSTR;
            rdata   <= '0;
        end else begin
            state <= state_nx;
            done  <= cmp || flt;
            fault <= flt;
            if (accept) begin
                kind_q  <= kind_nx;
                f3_q    <= funct3;
                addr_q  <= addr;
                wdata_q <= wdata;
            end
            if (cmp && kind_q == K_FETCH) instr <= mem.mem_rdata;
            if (cmp && kind_q == K_READ) rdata <= rext;
        end
    end
    lsu_align u_align (
        .funct3 (f3_q),
        .off    (addr_q[1:0]),
        .wdata  (wdata_q),
        .raw    (mem.mem_rdata),
        .wstrb  (strb),
        .wlane  (wlane),
        .rext   (rext)
    );
    // Memory side is driven only from latched values so it holds steady in WAIT.
    assign busy          = state == S_WAIT;
    assign mem.mem_valid = state == S_WAIT;
    assign mem.mem_addr  = {addr_q[31:2], 2'b00};
    assign mem.mem_wstrb = kind_q == K_WRITE ? strb : STRB_NONE;
    assign mem.mem_wdata = wlane;
    assign op            = instr[6:0];
    assign instr_funct3  = instr[14:12];
endmodule
